// File: rtl/dip_hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dip_hex_scan_ctrl
//   Sequencer for a two-digit DIP-switch-to-hex display.
//   - Double-flop synchronises the raw 8-bit switch value, then debounces it:
//     a value must be seen unchanged for DEB_CYCLES cycles before it is
//     committed to val_out.
//   - Scans the two hex nibbles onto one shared 7-segment bus:
//       SHOW_LO -> BLANK_LO -> SHOW_HI -> BLANK_HI -> SHOW_LO
//     SHOW states last DWELL_CYCLES, BLANK states last BLANK_CYCLES. The blank
//     gap between digits suppresses ghosting on the shared segment lines.
//   - ena=0 freezes debounce, scan FSM and dwell count, and blanks the display.
//
// Parameters
//   DEB_CYCLES    stable synchronised cycles needed to commit a value (>=1)
//   DWELL_CYCLES  cycles each digit is shown (>=1)
//   BLANK_CYCLES  cycles of blanking after each digit (>=1)
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   ena        in   1  0 = freeze block, blank display
//   sw_in      in   8  raw DIP switch value (asynchronous to clk)
//   seg_out    out  7  segments {g,f,e,d,c,b,a}, active high
//   dp_out     out  1  decimal point, active high
//   dig_sel    out  2  01 = low nibble, 10 = high nibble, 00 = none
//   val_out    out  8  debounced, committed switch value
//   val_valid  out  1  high once the first value has been committed
//
// Build option
//   SCAN_CHANGE_DP_EN : when defined, a commit that changes val_out lights the
//   decimal point during SHOW states until two BLANK_HI->SHOW_LO transitions
//   have passed. When undefined, dp_out is tied to 0.
// -----------------------------------------------------------------------------
module dip_hex_scan_ctrl #(
  parameter int DEB_CYCLES   = 4,
  parameter int DWELL_CYCLES = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] sw_in,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [1:0] dig_sel,
  output logic [7:0] val_out,
  output logic       val_valid
);

  // Debounce counter saturates at DEB_CYCLES, so it needs to hold that value.
  localparam int CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int DUR_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int DW      = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DW-1:0] BLANK_LAST = DW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    SHOW_LO  = 2'd0,
    BLANK_LO = 2'd1,
    SHOW_HI  = 2'd2,
    BLANK_HI = 2'd3
  } state_e;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Debounce path
  logic [7:0]    s1_q, s2_q;
  logic [7:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    val_q, val_d;
  logic          valid_q, valid_d;
  logic          commit;

  // Scan FSM
  state_e        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [DW-1:0] dwell_last;

  // Registered display outputs
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    valid_d = valid_q;
    commit  = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else begin
      // Committing an unchanged value is allowed: it only sets valid.
      if (cnt_q == DEB_LAST) commit = 1'b1;
      if (cnt_q != DEB_MAX)  cnt_d  = cnt_q + CW'(1);
    end
    if (commit) begin
      val_d   = cand_q;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    dwell_last = ((state_q == SHOW_LO) || (state_q == SHOW_HI)) ? DWELL_LAST : BLANK_LAST;
    state_d    = state_q;
    dwell_d    = dwell_q + DW'(1);
    if (dwell_q == dwell_last) begin
      dwell_d = '0;
      case (state_q)
        SHOW_LO:  state_d = BLANK_LO;
        BLANK_LO: state_d = SHOW_HI;
        SHOW_HI:  state_d = BLANK_HI;
        default:  state_d = SHOW_LO;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register; segments use the pre-edge val_out, i.e. they lag it by a cycle.
  always_comb begin
    seg_d = '0;
    dig_d = '0;
    if (ena) begin
      case (state_d)
        SHOW_LO: begin
          dig_d = 2'b01;
          seg_d = valid_q ? hex7(val_q[3:0]) : 7'h40;
        end
        SHOW_HI: begin
          dig_d = 2'b10;
          seg_d = valid_q ? hex7(val_q[7:4]) : 7'h40;
        end
        default: begin
          dig_d = 2'b00;
          seg_d = 7'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      state_q <= BLANK_HI;
      dwell_q <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
      if (ena) begin
        s1_q    <= sw_in;
        s2_q    <= s1_q;
        cand_q  <= cand_d;
        cnt_q   <= cnt_d;
        val_q   <= val_d;
        valid_q <= valid_d;
        state_q <= state_d;
        dwell_q <= dwell_d;
      end
    end
  end

`ifdef SCAN_CHANGE_DP_EN
  // Frame counter for the "value just changed" decimal point.
  logic [1:0] flag_q, flag_d;
  logic       dp_q, dp_d;

  always_comb begin
    flag_d = flag_q;
    if ((state_q == BLANK_HI) && (state_d == SHOW_LO) && (flag_q != 2'd0))
      flag_d = flag_q - 2'd1;
    // A fresh change re-arms even on the frame boundary.
    if (commit && (cand_q != val_q))
      flag_d = 2'd2;
    dp_d = ena && ((state_d == SHOW_LO) || (state_d == SHOW_HI)) && (flag_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 2'd0;
      dp_q   <= 1'b0;
    end else begin
      dp_q <= dp_d;
      if (ena) flag_q <= flag_d;
    end
  end

  assign dp_out = dp_q;
`else
  assign dp_out = 1'b0;
`endif

  assign seg_out   = seg_q;
  assign dig_sel   = dig_q;
  assign val_out   = val_q;
  assign val_valid = valid_q;

endmodule

// File: tb/tb_dip_hex_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dip_hex_scan_ctrl
//   Scenario bench for dip_hex_scan_ctrl at default parameters. Each scenario
//   queues the outputs it expects at given edge numbers (counted from the last
//   reset release) and compares them on the falling edge as time reaches them.
// -----------------------------------------------------------------------------
module tb_dip_hex_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] sw_in = 8'h00;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [1:0] dig_sel;
  logic [7:0] val_out;
  logic       val_valid;

`ifdef SCAN_CHANGE_DP_EN
  localparam logic DP_EN = 1'b1;
`else
  localparam logic DP_EN = 1'b0;
`endif

  localparam int S_SEG = 0, S_DIG = 1, S_VAL = 2, S_VLD = 3, S_DP = 4;

  typedef struct {
    int         at;
    int         sig;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;

  dip_hex_scan_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sw_in     (sw_in),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .dig_sel   (dig_sel),
    .val_out   (val_out),
    .val_valid (val_valid)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [7:0] obs(input int sig);
    case (sig)
      S_SEG:   return {1'b0, seg_out};
      S_DIG:   return {6'b0, dig_sel};
      S_VAL:   return val_out;
      S_VLD:   return {7'b0, val_valid};
      default: return {7'b0, dp_out};
    endcase
  endfunction

  function automatic string sname(input int sig);
    case (sig)
      S_SEG:   return "seg_out";
      S_DIG:   return "dig_sel";
      S_VAL:   return "val_out";
      S_VLD:   return "val_valid";
      default: return "dp_out";
    endcase
  endfunction

  task automatic push(input int at, input int sig, input logic [7:0] e);
    sb.push_back('{at, sig, e});
  endtask

  task automatic wait_cyc(input int t);
    for (int g = 0; g < 1000 && cyc < t; g++) @(negedge clk);
  endtask

  // Release-to-first-commit sequence with sw_in=00; ends at edge 12.
  task automatic test_startup(input string tag);
    exp_t it;
    push(1, S_DIG, 8'h00);  push(1, S_VLD, 8'h00);  push(1, S_SEG, 8'h00);
    push(2, S_DIG, 8'h01);  push(2, S_SEG, 8'h40);  push(2, S_DP, 8'h00);
    push(3, S_SEG, 8'h40);  push(3, S_VLD, 8'h00);
    push(4, S_VLD, 8'h01);  push(4, S_VAL, 8'h00);  push(4, S_SEG, 8'h40);
    push(5, S_SEG, 8'h3F);  push(9, S_DIG, 8'h01);
    push(10, S_DIG, 8'h00); push(10, S_SEG, 8'h00);
    push(12, S_DIG, 8'h02); push(12, S_SEG, 8'h3F);
    for (int g = 0; g < 200 && sb.size() > 0; g++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        it = sb.pop_front();
        n_tests++;
        if (it.at != cyc || obs(it.sig) !== it.exp) begin
          n_fail++;
          $display("FAIL %s %s @edge %0d: got %02h want %02h", tag, sname(it.sig), it.at, obs(it.sig), it.exp);
        end
      end
    end
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: %0d expectations left", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    n_tests += 5;
    if (seg_out !== 7'h00)  begin n_fail++; $display("FAIL reset seg_out: got %02h want 00", seg_out); end
    if (dig_sel !== 2'b00)  begin n_fail++; $display("FAIL reset dig_sel: got %0b want 00", dig_sel); end
    if (dp_out !== 1'b0)    begin n_fail++; $display("FAIL reset dp_out: got %0b want 0", dp_out); end
    if (val_out !== 8'h00)  begin n_fail++; $display("FAIL reset val_out: got %02h want 00", val_out); end
    if (val_valid !== 1'b0) begin n_fail++; $display("FAIL reset val_valid: got %0b want 0", val_valid); end
    sw_in = 8'h00;
    rst_n = 1'b1;
    test_startup("startup");
  endtask

  // sw_in=A5 from edge 12: sampled edge 13, committed edge 19.
  task automatic test_display();
    exp_t it;
    sw_in = 8'hA5;
    push(18, S_VAL, 8'h00);
    push(19, S_VAL, 8'hA5); push(19, S_VLD, 8'h01);
    for (int e = 22; e <= 29; e++) begin push(e, S_DIG, 8'h01); push(e, S_SEG, 8'h6D); end
    for (int e = 30; e <= 31; e++) begin push(e, S_DIG, 8'h00); push(e, S_SEG, 8'h00); end
    for (int e = 32; e <= 39; e++) begin push(e, S_DIG, 8'h02); push(e, S_SEG, 8'h77); end
    push(40, S_DIG, 8'h00);
    push(42, S_DIG, 8'h01); push(42, S_SEG, 8'h6D);
    for (int g = 0; g < 200 && sb.size() > 0; g++) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        it = sb.pop_front();
        n_tests++;
        if (it.at != cyc || obs(it.sig) !== it.exp) begin
          n_fail++;
          $display("FAIL display %s @edge %0d: got %02h want %02h", sname(it.sig), it.at, obs(it.sig), it.exp);
        end
      end
    end
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL display timeout: %0d expectations left", sb.size());
      sb.delete();
    end
  endtask

  // 5A/00 every 2 cycles from edge 44, final 5A at edge 64 -> commit edge 71.
  task automatic test_debounce_bounce();
    exp_t it;
    for (int e = 45; e <= 70; e++) push(e, S_VAL, 8'hA5);
    push(71, S_VAL, 8'h5A);
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          wait_cyc(44 + 2 * i);
          sw_in = (i % 2 == 0) ? 8'h5A : 8'h00;
        end
        wait_cyc(64);
        sw_in = 8'h5A;
      end
      begin
        for (int g = 0; g < 200 && sb.size() > 0; g++) begin
          @(negedge clk);
          while (sb.size() > 0 && sb[0].at <= cyc) begin
            it = sb.pop_front();
            n_tests++;
            if (it.at != cyc || obs(it.sig) !== it.exp) begin
              n_fail++;
              $display("FAIL bounce %s @edge %0d: got %02h want %02h", sname(it.sig), it.at, obs(it.sig), it.exp);
            end
          end
        end
        if (sb.size() > 0) begin
          n_tests++; n_fail++;
          $display("FAIL bounce timeout: %0d expectations left", sb.size());
          sb.delete();
        end
      end
    join
  endtask

  // Edge 74 is the 3rd SHOW_HI cycle; freeze for edges 75..84.
  task automatic test_ena_freeze();
    exp_t it;
    push(74, S_DIG, 8'h02); push(74, S_SEG, 8'h6D);
    for (int e = 75; e <= 84; e++) begin
      push(e, S_SEG, 8'h00); push(e, S_DIG, 8'h00); push(e, S_DP, 8'h00);
      push(e, S_VAL, 8'h5A); push(e, S_VLD, 8'h01);
    end
    for (int e = 85; e <= 89; e++) begin push(e, S_DIG, 8'h02); push(e, S_SEG, 8'h6D); end
    push(90, S_DIG, 8'h00);
    push(92, S_DIG, 8'h01); push(92, S_SEG, 8'h77); push(92, S_VAL, 8'h5A);
    fork
      begin
        wait_cyc(74);
        ena = 1'b0;
        sw_in = 8'h00;
        wait_cyc(84);
        sw_in = 8'h5A;
        ena = 1'b1;
      end
      begin
        for (int g = 0; g < 200 && sb.size() > 0; g++) begin
          @(negedge clk);
          while (sb.size() > 0 && sb[0].at <= cyc) begin
            it = sb.pop_front();
            n_tests++;
            if (it.at != cyc || obs(it.sig) !== it.exp) begin
              n_fail++;
              $display("FAIL ena %s @edge %0d: got %02h want %02h", sname(it.sig), it.at, obs(it.sig), it.exp);
            end
          end
        end
        if (sb.size() > 0) begin
          n_tests++; n_fail++;
          $display("FAIL ena timeout: %0d expectations left", sb.size());
          sb.delete();
        end
      end
    join
  endtask

  // Edge 94 is mid-SHOW_LO (after the 10-cycle stall).
  task automatic test_async_reset();
    wait_cyc(94);
    n_tests++;
    if (dig_sel !== 2'b01) begin n_fail++; $display("FAIL areset pre dig_sel: got %0b want 01", dig_sel); end
    rst_n = 1'b0;
    sw_in = 8'h00;
    #1;
    n_tests += 5;
    if (seg_out !== 7'h00)  begin n_fail++; $display("FAIL areset seg_out: got %02h want 00", seg_out); end
    if (dig_sel !== 2'b00)  begin n_fail++; $display("FAIL areset dig_sel: got %0b want 00", dig_sel); end
    if (dp_out !== 1'b0)    begin n_fail++; $display("FAIL areset dp_out: got %0b want 0", dp_out); end
    if (val_out !== 8'h00)  begin n_fail++; $display("FAIL areset val_out: got %02h want 00", val_out); end
    if (val_valid !== 1'b0) begin n_fail++; $display("FAIL areset val_valid: got %0b want 0", val_valid); end
    #1;
    rst_n = 1'b1;
    test_startup("restart");
  endtask

  // 00->11 commits at edge 19 (flag expires by edge 42); 11->12 commits at 59.
  task automatic test_change_dp();
    exp_t it;
    logic dpe;
    sw_in = 8'h11;
    push(19, S_VAL, 8'h11);
    for (int e = 52; e <= 89; e++) begin
      dpe = DP_EN && ((e == 59) || (e >= 62 && e <= 69) || (e >= 72 && e <= 79));
      push(e, S_DP, {7'b0, dpe});
      if (e == 58) push(e, S_VAL, 8'h11);
      if (e == 59) push(e, S_VAL, 8'h12);
      if (e == 62) begin push(e, S_SEG, 8'h5B); push(e, S_DIG, 8'h01); end
      if (e == 72) begin push(e, S_SEG, 8'h06); push(e, S_DIG, 8'h02); end
    end
    fork
      begin
        wait_cyc(52);
        sw_in = 8'h12;
      end
      begin
        for (int g = 0; g < 200 && sb.size() > 0; g++) begin
          @(negedge clk);
          while (sb.size() > 0 && sb[0].at <= cyc) begin
            it = sb.pop_front();
            n_tests++;
            if (it.at != cyc || obs(it.sig) !== it.exp) begin
              n_fail++;
              $display("FAIL dp %s @edge %0d: got %02h want %02h", sname(it.sig), it.at, obs(it.sig), it.exp);
            end
          end
        end
        if (sb.size() > 0) begin
          n_tests++; n_fail++;
          $display("FAIL dp timeout: %0d expectations left", sb.size());
          sb.delete();
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_display();
    test_debounce_bounce();
    test_ena_freeze();
    test_async_reset();
    test_change_dp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
